// File: rtl/fetch_lmsm_if.sv
// rtl/fetch_lmsm_if.sv - fetch stage bus: imem port, hazard/redirect controls, pipe1 register
//
// Purpose: groups every non-clock signal of fetch_lmsm into one bundle.
// Ports (signals):
//   imem_addr   [15:0] fetch -> imem   instruction address (equals PC)
//   imem_data   [15:0] imem  -> fetch  instruction word, same cycle
//   stall              hazard -> fetch hold every register
//   flush              redirect -> fetch kill in-flight work, jump to flush_pc
//   flush_pc    [15:0] redirect target
//   pipe1PC     [15:0] PC of the pipe1 instruction
//   pipe1IR     [15:0] instruction / LM-SM micro-op in pipe1
//   pipe1Offset [2:0]  transfer index of an LM/SM micro-op
//   pipe1Valid         pipe1 holds a real instruction
//   busy               fetch is expanding an LM/SM register list
// Modports: master = fetch stage, slave = surrounding pipeline / memory.
interface fetch_lmsm_if;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        flush;
  logic [15:0] flush_pc;
  logic [15:0] pipe1PC;
  logic [15:0] pipe1IR;
  logic [2:0]  pipe1Offset;
  logic        pipe1Valid;
  logic        busy;

  modport master (
    output imem_addr, pipe1PC, pipe1IR, pipe1Offset, pipe1Valid, busy,
    input  imem_data, stall, flush, flush_pc
  );

  modport slave (
    input  imem_addr, pipe1PC, pipe1IR, pipe1Offset, pipe1Valid, busy,
    output imem_data, stall, flush, flush_pc
  );
endinterface

// File: rtl/fetch_lmsm.sv
// rtl/fetch_lmsm.sv - instruction fetch with LM/SM micro-op expansion
//
// Purpose: holds the PC, reads instruction memory combinationally and loads
// the fetch/decode register (pipe1). LM/SM instructions are split into one
// micro-op per set bit of IR[7:0], each carrying a one-hot register list.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_lmsm_if.master (imem port, stall/flush controls, pipe1 outputs)
module fetch_lmsm #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_IR   = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_lmsm_if.master  bus
);

  typedef enum logic {
    FETCH = 1'b0,
    SEQ   = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  seq_ir_q, seq_ir_d;
  logic [15:0] seq_pc_q, seq_pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] p1_pc_q, p1_pc_d;
  logic [15:0] p1_ir_q, p1_ir_d;
  logic [2:0]  p1_off_q, p1_off_d;
  logic        p1_valid_q, p1_valid_d;

  logic [7:0]  fetch_list;
  logic [7:0]  fetch_lsb;
  logic [7:0]  mask_lsb;
  logic        is_lmsm;

  // x & -x isolates the lowest set bit (zero when x is zero).
  assign fetch_list = bus.imem_data[7:0];
  assign fetch_lsb  = fetch_list & (~fetch_list + 8'd1);
  assign mask_lsb   = mask_q & (~mask_q + 8'd1);
  // LM = 0110, SM = 0111: top three opcode bits are 011.
  assign is_lmsm    = (bus.imem_data[15:13] == 3'b011);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      mask_q     <= 8'h00;
      seq_ir_q   <= 8'h00;
      seq_pc_q   <= 16'h0000;
      cnt_q      <= 3'd0;
      p1_pc_q    <= 16'h0000;
      p1_ir_q    <= NOP_IR;
      p1_off_q   <= 3'd0;
      p1_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mask_q     <= mask_d;
      seq_ir_q   <= seq_ir_d;
      seq_pc_q   <= seq_pc_d;
      cnt_q      <= cnt_d;
      p1_pc_q    <= p1_pc_d;
      p1_ir_q    <= p1_ir_d;
      p1_off_q   <= p1_off_d;
      p1_valid_q <= p1_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mask_d     = mask_q;
    seq_ir_d   = seq_ir_q;
    seq_pc_d   = seq_pc_q;
    cnt_d      = cnt_q;
    p1_pc_d    = p1_pc_q;
    p1_ir_d    = p1_ir_q;
    p1_off_d   = p1_off_q;
    p1_valid_d = p1_valid_q;

    if (bus.flush) begin
      // Redirect wins over stall; any unissued micro-ops are dropped.
      pc_d       = bus.flush_pc;
      state_d    = FETCH;
      mask_d     = 8'h00;
      cnt_d      = 3'd0;
      p1_valid_d = 1'b0;
      p1_ir_d    = NOP_IR;
      p1_off_d   = 3'd0;
    end else if (!bus.stall) begin
      unique case (state_q)
        FETCH: begin
          pc_d = pc_q + 16'd1;
          if (!is_lmsm) begin
            p1_ir_d    = bus.imem_data;
            p1_pc_d    = pc_q;
            p1_off_d   = 3'd0;
            p1_valid_d = 1'b1;
          end else if (fetch_list == 8'h00) begin
            // Empty register list: consumed as a bubble.
            p1_valid_d = 1'b0;
            p1_ir_d    = NOP_IR;
          end else begin
            p1_ir_d    = {bus.imem_data[15:8], fetch_lsb};
            p1_pc_d    = pc_q;
            p1_off_d   = 3'd0;
            p1_valid_d = 1'b1;
            mask_d     = fetch_list & ~fetch_lsb;
            seq_ir_d   = bus.imem_data[15:8];
            seq_pc_d   = pc_q;
            cnt_d      = 3'd1;
            if ((fetch_list & ~fetch_lsb) != 8'h00) begin
              state_d = SEQ;
            end
          end
        end
        SEQ: begin
          // PC already points past the LM/SM; imem_data is ignored here.
          p1_ir_d    = {seq_ir_q, mask_lsb};
          p1_pc_d    = seq_pc_q;
          p1_off_d   = cnt_q;
          p1_valid_d = 1'b1;
          mask_d     = mask_q & ~mask_lsb;
          cnt_d      = cnt_q + 3'd1;
          if ((mask_q & ~mask_lsb) == 8'h00) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pipe1PC     = p1_pc_q;
  assign bus.pipe1IR     = p1_ir_q;
  assign bus.pipe1Offset = p1_off_q;
  assign bus.pipe1Valid  = p1_valid_q;
  assign bus.busy        = (state_q == SEQ);

endmodule

// File: tb/tb_fetch_lmsm.sv
// tb/tb_fetch_lmsm.sv - directed self-checking bench for fetch_lmsm
module tb_fetch_lmsm;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [15:0] imem [0:65535];

  fetch_lmsm_if bus ();

  fetch_lmsm #(
    .RESET_PC (16'h0000),
    .NOP_IR   (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.imem_data = imem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_p1(input string tag, input logic [15:0] pc, input logic [15:0] ir,
                           input logic [2:0] off, input logic valid, input logic busy,
                           input logic [15:0] addr);
    check({tag, ".pc"},    bus.pipe1PC, pc);
    check({tag, ".ir"},    bus.pipe1IR, ir);
    check({tag, ".off"},   {13'd0, bus.pipe1Offset}, {13'd0, off});
    check({tag, ".valid"}, {15'd0, bus.pipe1Valid}, {15'd0, valid});
    check({tag, ".busy"},  {15'd0, bus.busy}, {15'd0, busy});
    check({tag, ".addr"},  bus.imem_addr, addr);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 65536; i++) imem[i] = 16'h1000;
    imem[0]        = 16'h0A50;
    imem[1]        = 16'h1283;
    imem[2]        = 16'h3E01;
    imem[3]        = 16'h2222;
    imem[4]        = 16'h6C25;
    imem[5]        = 16'h7E00;
    imem[6]        = 16'h7E80;
    imem[7]        = 16'h60FF;
    imem[16'h0040] = 16'h4444;
    imem[16'hFFFF] = 16'h5555;

    rst_n        = 1'b0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    bus.flush_pc = 16'h0000;
    #23;
    expect_p1("reset", 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b1;

    tick(); expect_p1("seq0", 16'h0000, 16'h0A50, 3'd0, 1'b1, 1'b0, 16'h0001);
    tick(); expect_p1("seq1", 16'h0001, 16'h1283, 3'd0, 1'b1, 1'b0, 16'h0002);
    tick(); expect_p1("seq2", 16'h0002, 16'h3E01, 3'd0, 1'b1, 1'b0, 16'h0003);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_p1("stall", 16'h0002, 16'h3E01, 3'd0, 1'b1, 1'b0, 16'h0003);
    end
    bus.stall = 1'b0;
    tick(); expect_p1("resume", 16'h0003, 16'h2222, 3'd0, 1'b1, 1'b0, 16'h0004);

    tick(); expect_p1("lm0", 16'h0004, 16'h6C01, 3'd0, 1'b1, 1'b1, 16'h0005);
    tick(); expect_p1("lm1", 16'h0004, 16'h6C04, 3'd1, 1'b1, 1'b1, 16'h0005);
    tick(); expect_p1("lm2", 16'h0004, 16'h6C20, 3'd2, 1'b1, 1'b0, 16'h0005);

    tick();
    check("empty.valid", {15'd0, bus.pipe1Valid}, 16'h0000);
    check("empty.ir",    bus.pipe1IR, 16'h0000);
    check("empty.busy",  {15'd0, bus.busy}, 16'h0000);
    check("empty.addr",  bus.imem_addr, 16'h0006);

    tick(); expect_p1("single", 16'h0006, 16'h7E80, 3'd0, 1'b1, 1'b0, 16'h0007);

    tick(); expect_p1("ff0", 16'h0007, 16'h6001, 3'd0, 1'b1, 1'b1, 16'h0008);
    tick(); expect_p1("ff1", 16'h0007, 16'h6002, 3'd1, 1'b1, 1'b1, 16'h0008);
    bus.flush    = 1'b1;
    bus.flush_pc = 16'h0040;
    tick();
    check("fl.valid", {15'd0, bus.pipe1Valid}, 16'h0000);
    check("fl.ir",    bus.pipe1IR, 16'h0000);
    check("fl.off",   {13'd0, bus.pipe1Offset}, 16'h0000);
    check("fl.busy",  {15'd0, bus.busy}, 16'h0000);
    check("fl.addr",  bus.imem_addr, 16'h0040);
    bus.flush = 1'b0;
    tick(); expect_p1("redir", 16'h0040, 16'h4444, 3'd0, 1'b1, 1'b0, 16'h0041);

    bus.flush    = 1'b1;
    bus.stall    = 1'b1;
    bus.flush_pc = 16'hFFFF;
    tick();
    check("fs.addr",  bus.imem_addr, 16'hFFFF);
    check("fs.valid", {15'd0, bus.pipe1Valid}, 16'h0000);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    tick(); expect_p1("wrap", 16'hFFFF, 16'h5555, 3'd0, 1'b1, 1'b0, 16'h0000);

    rst_n = 1'b0;
    #2;
    expect_p1("areset", 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_lmsm.md
Name: fetch_lmsm

Overview:
Instruction-fetch stage that drives the fetch/decode pipeline register (pipe1) feeding the decode stage with PC and IR.
Holds the PC and reads instruction memory combinationally.
Expands every LM/SM (opcode 0110/0111) into one micro-op per set bit of IR[7:0], so decode only ever sees a one-hot register list.
Honours a stall from hazard logic and a flush/redirect from branch, jump or R7-writeback logic.

Parameters:
RESET_PC  16'h0000  PC value loaded on reset
NOP_IR    16'h0000  IR value driven on pipe1IR whenever pipe1Valid=0

Ports:
clk           input   1   rising-edge clock
rst_n         input   1   asynchronous active-low reset
imem_addr     output  16  instruction memory address; combinational, equals PC register
imem_data     input   16  instruction word at imem_addr, same cycle
stall         input   1   1 = hold every register of this block
flush         input   1   1 = redirect fetch to flush_pc and kill the in-flight sequence
flush_pc      input   16  redirect target
pipe1PC       output  16  PC of the instruction currently in pipe1
pipe1IR       output  16  instruction or micro-op currently in pipe1
pipe1Offset   output  3   transfer index of an LM/SM micro-op (0..7); 0 for all other instructions
pipe1Valid    output  1   pipe1 holds a real instruction
busy          output  1   1 while in state SEQ

Behaviour:
- Reset (rst_n=0, asynchronous):
  - PC=RESET_PC, state=FETCH, mask=0, seqIR=0, seqPC=0, cnt=0.
  - pipe1PC=0, pipe1IR=NOP_IR, pipe1Offset=0, pipe1Valid=0, busy=0.
- Priority per rising edge: flush > stall > normal.
- flush=1:
  - PC<=flush_pc, state<=FETCH, mask<=0, cnt<=0.
  - pipe1Valid<=0, pipe1IR<=NOP_IR, pipe1Offset<=0.
  - Applies even when stall=1 and even in SEQ; any remaining micro-ops are discarded.
- stall=1 (flush=0): all state and outputs hold; imem_addr stays at PC.
- Latency: the word fetched when PC=p appears on pipe1 one cycle later, with pipe1PC=p.
- State FETCH, normal cycle with I=imem_data:
  - Non-LM/SM opcode: pipe1IR<=I, pipe1PC<=PC, pipe1Offset<=0, pipe1Valid<=1, PC<=PC+1.
  - LM/SM with I[7:0]==0: pipe1Valid<=0, pipe1IR<=NOP_IR, PC<=PC+1. The instruction is consumed as a no-op.
  - LM/SM with I[7:0]!=0:
    - Let L = lowest set bit of I[7:0].
    - pipe1IR<={I[15:8], L}, pipe1PC<=PC, pipe1Offset<=0, pipe1Valid<=1, PC<=PC+1.
    - mask<=I[7:0] & ~L; seqIR<=I[15:8]; seqPC<=PC; cnt<=1.
    - If the remaining mask is nonzero, state<=SEQ; otherwise stay in FETCH.
- State SEQ, normal cycle:
  - Let L = lowest set bit of mask.
  - pipe1IR<={seqIR, L}, pipe1PC<=seqPC, pipe1Offset<=cnt, pipe1Valid<=1.
  - mask<=mask & ~L, cnt<=cnt+1, PC holds, imem_data is ignored.
  - If mask & ~L == 0, state<=FETCH.
- busy=1 exactly while state==SEQ.
- Micro-op count equals popcount(IR[7:0]), maximum 8 (cnt 0..7). IR[8] is passed through untouched.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000.
- Opcodes outside LM/SM, including unused ones, are passed through unchanged.

Test Plan:
- Reset then sequential fetch: rst_n low→high, imem[0..2]=16'h0A50,16'h1283,16'h3E01 → pipe1 shows (PC0,0A50),(PC1,1283),(PC2,3E01) on consecutive cycles, pipe1Valid=1, pipe1Offset=0.
- Stall hold: stall=1 for 3 cycles mid-stream → imem_addr, pipe1PC and pipe1IR frozen; after release, fetch resumes at the next PC with no lost or duplicated instruction.
- LM expansion: imem[4]=16'h6C25 → three micro-ops 6C01,6C04,6C20 with pipe1PC=4 and offsets 0,1,2; busy=1 for 2 cycles; next instruction comes from PC 5.
- Empty list and single bit:
  - SM 16'h7E00 → one cycle with pipe1Valid=0, busy never set.
  - SM 16'h7E80 → single micro-op 7E80 at offset 0, busy never set.
- Flush in SEQ: LM 16'h60FF, then flush=1 with flush_pc=16'h0040 after the second micro-op → pipe1Valid=0 next cycle, busy=0, next fetch from 16'h0040.
- Flush beats stall and PC wraps: flush=1 with stall=1 and flush_pc=16'hFFFF → PC=FFFF; after one normal cycle imem_addr=16'h0000 and pipe1PC=16'hFFFF.
